program_counter_stack: RTL and testbench
========================================

// Module: program_counter_stack
// PURPOSE
//  Next-generation program counter for the SAP CPU: parametrised width, reset vector and step.
//  Adds an internal return-address stack so the controller can execute CALL/RET without using RAM.
//  Sits in the datapath and drives the address bus (o_data). Its load/call/ret strobes come from the control sequencer.
// PARAMETERS
//  WIDTH      16  counter and address width in bits (>=2)
//  DEPTH      8   return-stack entries (>=1)
//  RESET_ADDR 0   counter value after reset (WIDTH bits)
//  STEP       1   increment applied on i_counter_enable (1..2**WIDTH-1)
// PORTS
//  clk               in  1                  rising-edge system clock
//  rst_n             in  1                  async active-low reset
//  clk_en            in  1                  global step enable; state updates only when high
//  i_halt            in  1                  freezes all state (counter, stack, flags)
//  i_counter_enable  in  1                  counter <= counter + STEP
//  i_load_enable     in  1                  counter <= i_load_data (jump)
//  i_call            in  1                  push counter, then counter <= i_load_data
//  i_ret             in  1                  counter <= popped top of stack
//  i_clear_err       in  1                  clears sticky error flags
//  i_load_data       in  WIDTH              jump/call target
//  o_data            out WIDTH              current counter
//  o_stack_top       out WIDTH              top entry (0 when empty)
//  o_depth           out $clog2(DEPTH+1)    number of valid entries
//  o_full            out 1                  o_depth == DEPTH
//  o_empty           out 1                  o_depth == 0
//  o_overflow        out 1                  sticky: CALL attempted while full
//  o_underflow       out 1                  sticky: RET attempted while empty
// BEHAVIOUR
//  - Reset (async assert, sync release):
//      o_data = RESET_ADDR; o_depth = 0; o_overflow = o_underflow = 0.
//      Stack RAM contents are don't-care. o_stack_top reads 0 while empty.
//  - Update condition: upd = clk_en & ~i_halt. All registers hold when upd = 0, including i_clear_err.
//  - Per-cycle op priority when upd = 1: i_ret > i_call > i_load_enable > i_counter_enable > hold.
//      Only the highest asserted op takes effect; lower-priority ops are ignored that cycle.
//  - RET, not empty: counter <= stack[depth-1]; depth - 1.
//  - RET, empty: counter holds; o_underflow <= 1.
//  - CALL, not full: stack[depth] <= counter (the current value, already past the operand); depth + 1; counter <= i_load_data.
//  - CALL, full: no push; counter holds (no jump); o_overflow <= 1.
//  - LOAD: counter <= i_load_data; stack untouched.
//  - INC: counter <= (counter + STEP) mod 2**WIDTH. Wraps silently; no flag.
//  - Errors: set has priority over i_clear_err in the same cycle. Otherwise i_clear_err & upd clears both flags.
//  - Latency: every op is visible on the outputs one clk after the enabling edge.
//      o_full, o_empty and o_stack_top are combinational from the registered state.
//  - Reset mid-call/ret: state returns to reset values regardless; no partial push survives.
// TESTING
//  1 Reset with WIDTH=16, RESET_ADDR=16'h0100: o_data=0100, o_depth=0, o_empty=1, flags 0.
//    Then 3 INC cycles -> o_data=0103.
//  2 INC at o_data=FFFF with STEP=1 -> 0000, no flag. With STEP=2 at FFFF -> 0001.
//  3 From 0010: CALL to 0200 -> o_data=0200, o_stack_top=0010, depth 1.
//    Then CALL to 0300 -> depth 2. RET -> 0200 (stack top now 0010). RET -> 0010, depth 0.
//  4 DEPTH=2: three CALLs -> third leaves counter at the 2nd target, depth 2, o_full=1, o_overflow=1.
//    i_clear_err -> flag 0.
//  5 Empty RET at 0042 -> o_data stays 0042, o_underflow=1.
//    Then i_ret+i_clear_err in one cycle -> o_underflow stays 1.
//  6 All of i_ret, i_call, i_load_enable, i_counter_enable with depth 1 -> pure RET.
//    Same ops with clk_en=0 or i_halt=1 -> nothing changes.
//    Assert rst_n low between edges -> outputs reset immediately.

Source files
------------

// File: rtl/program_counter_stack.sv
// SAP program counter with an internal return-address stack for CALL/RET.
// Ops resolve by priority RET > CALL > LOAD > INC; all state holds unless clk_en & ~i_halt.
module program_counter_stack #(
    parameter int               WIDTH      = 16,
    parameter int               DEPTH      = 8,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [WIDTH-1:0] STEP       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic                       i_halt,
    input  logic                       i_counter_enable,
    input  logic                       i_load_enable,
    input  logic                       i_call,
    input  logic                       i_ret,
    input  logic                       i_clear_err,
    input  logic [WIDTH-1:0]           i_load_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [WIDTH-1:0]           o_stack_top,
    output logic [$clog2(DEPTH+1)-1:0] o_depth,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_CALL,
        OP_RET
    } op_e;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, unf_q;
    logic             ovf_set, unf_set, push;
    logic             upd, full, empty;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic [WIDTH-1:0] stack_mem [DEPTH];
    op_e              op;

    assign upd    = clk_en & ~i_halt;
    assign full   = (depth_q == DW'(DEPTH));
    assign empty  = (depth_q == '0);
    assign wr_idx = AW'(depth_q);
    assign rd_idx = AW'(depth_q - DW'(1));

    always_comb begin
        op = OP_HOLD;
        if (i_ret)                 op = OP_RET;
        else if (i_call)           op = OP_CALL;
        else if (i_load_enable)    op = OP_LOAD;
        else if (i_counter_enable) op = OP_INC;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        depth_d = depth_q;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (op)
            OP_RET: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    cnt_d   = stack_mem[rd_idx];
                    depth_d = depth_q - DW'(1);
                end
            end
            OP_CALL: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    push    = 1'b1;
                    cnt_d   = i_load_data;
                    depth_d = depth_q + DW'(1);
                end
            end
            OP_LOAD: cnt_d = i_load_data;
            OP_INC:  cnt_d = cnt_q + STEP;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= RESET_ADDR;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (upd) begin
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            // A flag being set this cycle wins over a simultaneous clear.
            ovf_q   <= ovf_set | (ovf_q & ~i_clear_err);
            unf_q   <= unf_set | (unf_q & ~i_clear_err);
        end
    end

    // NOTE: the stack RAM is deliberately not reset; depth_q alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (upd && push) begin
            stack_mem[wr_idx] <= cnt_q;
        end
    end

    assign o_data      = cnt_q;
    assign o_depth     = depth_q;
    assign o_full      = full;
    assign o_empty     = empty;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
    assign o_stack_top = empty ? '0 : stack_mem[rd_idx];

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack: three instances share stimulus
// (default, STEP=2, DEPTH=2) and are checked against hand-computed values.
module tb_program_counter_stack;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, i_halt;
    logic        i_counter_enable, i_load_enable, i_call, i_ret, i_clear_err;
    logic [15:0] i_load_data;

    logic [15:0] a_data, a_top, b_data, b_top, c_data, c_top;
    logic [3:0]  a_depth, b_depth;
    logic [1:0]  c_depth;
    logic        a_full, a_empty, a_ovf, a_unf;
    logic        b_full, b_empty, b_ovf, b_unf;
    logic        c_full, c_empty, c_ovf, c_unf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    program_counter_stack #(.WIDTH(16), .DEPTH(8), .RESET_ADDR(16'h0100), .STEP(16'd1)) u_a (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_halt(i_halt),
        .i_counter_enable(i_counter_enable), .i_load_enable(i_load_enable),
        .i_call(i_call), .i_ret(i_ret), .i_clear_err(i_clear_err), .i_load_data(i_load_data),
        .o_data(a_data), .o_stack_top(a_top), .o_depth(a_depth), .o_full(a_full),
        .o_empty(a_empty), .o_overflow(a_ovf), .o_underflow(a_unf)
    );

    program_counter_stack #(.WIDTH(16), .DEPTH(8), .RESET_ADDR(16'h0100), .STEP(16'd2)) u_b (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_halt(i_halt),
        .i_counter_enable(i_counter_enable), .i_load_enable(i_load_enable),
        .i_call(i_call), .i_ret(i_ret), .i_clear_err(i_clear_err), .i_load_data(i_load_data),
        .o_data(b_data), .o_stack_top(b_top), .o_depth(b_depth), .o_full(b_full),
        .o_empty(b_empty), .o_overflow(b_ovf), .o_underflow(b_unf)
    );

    program_counter_stack #(.WIDTH(16), .DEPTH(2), .RESET_ADDR(16'h0100), .STEP(16'd1)) u_c (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_halt(i_halt),
        .i_counter_enable(i_counter_enable), .i_load_enable(i_load_enable),
        .i_call(i_call), .i_ret(i_ret), .i_clear_err(i_clear_err), .i_load_data(i_load_data),
        .o_data(c_data), .o_stack_top(c_top), .o_depth(c_depth), .o_full(c_full),
        .o_empty(c_empty), .o_overflow(c_ovf), .o_underflow(c_unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Apply one op set for a single clock edge; outputs sampled 1ns after the edge.
    task automatic op(input logic ret, input logic call, input logic ld, input logic inc,
                      input logic clr, input logic [15:0] data);
        i_ret = ret; i_call = call; i_load_enable = ld; i_counter_enable = inc;
        i_clear_err = clr; i_load_data = data;
        @(posedge clk); #1;
        i_ret = 0; i_call = 0; i_load_enable = 0; i_counter_enable = 0; i_clear_err = 0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0; #3; rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 0; clk_en = 1; i_halt = 0;
        i_counter_enable = 0; i_load_enable = 0; i_call = 0; i_ret = 0; i_clear_err = 0;
        i_load_data = '0;
        #12;
        check("rst_data",  a_data, 32'h0100);
        check("rst_depth", a_depth, 0);
        check("rst_empty", a_empty, 1);
        check("rst_full",  a_full, 0);
        check("rst_ovf",   a_ovf, 0);
        check("rst_unf",   a_unf, 0);
        check("rst_top",   a_top, 0);
        @(negedge clk); rst_n = 1;

        // Increment and wrap
        repeat (3) op(0, 0, 0, 1, 0, 16'h0);
        check("inc3", a_data, 32'h0103);
        op(0, 0, 1, 0, 0, 16'hFFFF);
        check("load_ffff", a_data, 32'hFFFF);
        op(0, 0, 0, 1, 0, 16'h0);
        check("wrap_step1", a_data, 32'h0000);
        check("wrap_step2", b_data, 32'h0001);
        check("wrap_noflag", {a_ovf, a_unf}, 0);

        // Nested CALL/RET
        op(0, 0, 1, 0, 0, 16'h0010);
        op(0, 1, 0, 0, 0, 16'h0200);
        check("call1_data",  a_data, 32'h0200);
        check("call1_top",   a_top, 32'h0010);
        check("call1_depth", a_depth, 1);
        op(0, 1, 0, 0, 0, 16'h0300);
        check("call2_data",  a_data, 32'h0300);
        check("call2_depth", a_depth, 2);
        check("call2_top",   a_top, 32'h0200);
        op(1, 0, 0, 0, 0, 16'h0);
        check("ret1_data",  a_data, 32'h0200);
        check("ret1_top",   a_top, 32'h0010);
        check("ret1_depth", a_depth, 1);
        op(1, 0, 0, 0, 0, 16'h0);
        check("ret2_data",  a_data, 32'h0010);
        check("ret2_depth", a_depth, 0);
        check("ret2_empty", a_empty, 1);

        // Overflow on the DEPTH=2 instance
        pulse_reset();
        op(0, 1, 0, 0, 0, 16'h0200);
        op(0, 1, 0, 0, 0, 16'h0300);
        check("fill_full", c_full, 1);
        check("fill_ovf",  c_ovf, 0);
        op(0, 1, 0, 0, 0, 16'h0400);
        check("ovf_data",  c_data, 32'h0300);
        check("ovf_depth", c_depth, 2);
        check("ovf_full",  c_full, 1);
        check("ovf_flag",  c_ovf, 1);
        check("ovf_top",   c_top, 32'h0200);
        op(0, 0, 0, 0, 1, 16'h0);
        check("ovf_clear", c_ovf, 0);

        // Underflow; set beats clear
        pulse_reset();
        op(0, 0, 1, 0, 0, 16'h0042);
        op(1, 0, 0, 0, 0, 16'h0);
        check("unf_data", a_data, 32'h0042);
        check("unf_flag", a_unf, 1);
        op(1, 0, 0, 0, 1, 16'h0);
        check("unf_set_wins", a_unf, 1);
        check("unf_data2",    a_data, 32'h0042);
        op(0, 0, 0, 0, 1, 16'h0);
        check("unf_clear", a_unf, 0);

        // Priority: all ops at depth 1 act as a pure RET
        op(0, 0, 1, 0, 0, 16'h0050);
        op(0, 1, 0, 0, 0, 16'h0060);
        op(1, 1, 1, 1, 0, 16'h0070);
        check("prio_data",  a_data, 32'h0050);
        check("prio_depth", a_depth, 0);
        check("prio_ovf",   a_ovf, 0);
        op(0, 1, 0, 0, 0, 16'h0060);

        // Gating: clk_en low, then halt high
        clk_en = 0;
        op(1, 1, 1, 1, 1, 16'h0070);
        check("clken_data",  a_data, 32'h0060);
        check("clken_depth", a_depth, 1);
        clk_en = 1; i_halt = 1;
        op(1, 1, 1, 1, 1, 16'h0070);
        check("halt_data",  a_data, 32'h0060);
        check("halt_depth", a_depth, 1);
        check("halt_top",   a_top, 32'h0050);
        i_halt = 0;

        // Asynchronous reset between edges
        rst_n = 0; #2;
        check("arst_data",  a_data, 32'h0100);
        check("arst_depth", a_depth, 0);
        check("arst_top",   a_top, 0);
        #2; rst_n = 1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
